// File: rtl/rr_issue_select8_if.sv
// Issue-select handshake bundle: RS ready lines in, registered grant out.
interface rr_issue_select8_if #(
   parameter int unsigned N_REQ = 8,
   parameter int unsigned IDX_W = 3
);
   localparam int unsigned CNT_W = 8;

   logic [N_REQ-1:0] req;
   logic             flush;
   logic             issue_ready;
   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;
   logic [N_REQ-1:0] grant_onehot;
   logic [CNT_W-1:0] stall_cnt;

   // Requester / consumer side (reservation station plus issue stage)
   modport master (
      output req, flush, issue_ready,
      input  grant_valid, grant_idx, grant_onehot, stall_cnt
   );

   // Selector side
   modport slave (
      input  req, flush, issue_ready,
      output grant_valid, grant_idx, grant_onehot, stall_cnt
   );
endinterface

// File: rtl/rr_issue_select8.sv
// Round-robin issue selector for an 8-entry reservation station.
// One registered grant slot; refilled when empty or when the consumer accepts.
module rr_issue_select8 #(
   parameter int unsigned N_REQ    = 8,
   parameter int unsigned IDX_W    = 3,
   parameter int unsigned PTR_INIT = 0
) (
   input logic               clk,
   input logic               reset,
   rr_issue_select8_if.slave bus
);
   localparam int unsigned      CNT_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] grant_idx;
   logic [N_REQ-1:0] grant_onehot;
   logic [CNT_W-1:0] stall_cnt;
   logic [IDX_W-1:0] ptr;

   logic             acc_c;
   logic             load_c;
   logic [N_REQ-1:0] cand_c;
   logic             found_c;
   logic [IDX_W-1:0] win_c;
   logic [IDX_W-1:0] scan_c;

   // Accept / refill decode; the just-accepted entry is masked out of the candidates
   assign acc_c  = (state == HOLD) & bus.issue_ready;
   assign load_c = (state == EMPTY) | acc_c;
   assign cand_c = bus.req & ~(acc_c ? grant_onehot : '0);

   // Circular first-set scan starting at the priority pointer
   always_comb begin
      found_c = 1'b0;
      win_c   = '0;
      scan_c  = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         scan_c = ptr + IDX_W'(k);
         if (!found_c && cand_c[scan_c]) begin
            found_c = 1'b1;
            win_c   = scan_c;
         end
      end
   end

   // Grant slot, pointer and stall counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= EMPTY;
         grant_idx    <= '0;
         grant_onehot <= '0;
         stall_cnt    <= '0;
         ptr          <= IDX_W'(PTR_INIT);
      end else begin
         // Pointer follows accepts even when a flush squashes the refill
         if (acc_c) begin
            ptr <= grant_idx + IDX_W'(1);
         end

         if ((state == HOLD) && !bus.issue_ready && !bus.flush && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end

         if (bus.flush) begin
            state        <= EMPTY;
            grant_onehot <= '0;
         end else if (load_c) begin
            if (found_c) begin
               state        <= HOLD;
               grant_idx    <= win_c;
               grant_onehot <= N_REQ'(1) << win_c;
            end else begin
               state        <= EMPTY;
               grant_onehot <= '0;
            end
         end
      end
   end

   assign bus.grant_valid  = (state == HOLD);
   assign bus.grant_idx    = grant_idx;
   assign bus.grant_onehot = grant_onehot;
   assign bus.stall_cnt    = stall_cnt;
endmodule
